// File: rtl/timer_host_if.sv
// Host-side register interface for the 4-bit period timer: bus decode, start/period handoff,
// sticky completion status, event counter and interrupt. Optional auto-reload: TIMER_HOST_AUTORELOAD_EN.
module timer_host_if #(
  parameter int unsigned EVT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_req,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_ack,
  input  logic       timer_done,
  output logic       timer_start,
  output logic [3:0] timer_period,
  output logic       irq
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2
  } state_e;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPeriod = 2'd1;
  localparam logic [1:0] AddrStatus = 2'd2;
  localparam logic [1:0] AddrEvents = 2'd3;

  state_e state_q, state_d;

  logic             ack_q, ack_d;
  logic             we_q;
  logic [1:0]       addr_q;
  logic [3:0]       wdata_q;
  logic             irq_en_q, irq_en_d;
  logic             auto_q;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       period_q, period_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [EVT_W-1:0] events_q, events_d;
  logic             irq_q, irq_d;

  logic wr, rd, wr_ctrl, start_req, rd_status, busy, done_evt;
  logic [7:0] evt_rd;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[7:4];

  // Access fields are captured on the request cycle and acted on in the ack cycle.
  assign wr        = ack_q & we_q;
  assign rd        = ack_q & ~we_q;
  assign wr_ctrl   = wr && (addr_q == AddrCtrl);
  assign start_req = wr_ctrl & wdata_q[0];
  assign rd_status = rd && (addr_q == AddrStatus);
  assign busy      = (state_q != StIdle);
  assign done_evt  = timer_done && (state_q == StRun);
  assign evt_rd    = 8'(events_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_req) state_d = StArm;
      StArm:   state_d = StRun;
      StRun:   if (done_evt) state_d = auto_q ? StArm : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    timer_start  = (state_q == StArm);
    timer_period = period_q;
    irq          = irq_q;
    bus_ack      = ack_q;
    bus_rdata    = 8'h00;
    if (rd) begin
      case (addr_q)
        AddrCtrl:   bus_rdata = {5'b0, auto_q, irq_en_q, 1'b0};
        AddrPeriod: bus_rdata = {4'b0, shadow_q};
        AddrStatus: bus_rdata = {5'b0, err_q, busy, done_q};
        AddrEvents: bus_rdata = evt_rd;
        default:    bus_rdata = 8'h00;
      endcase
    end
  end

  // Register next-state: sets win over read-to-clear, clear wins over increment.
  always_comb begin
    ack_d    = bus_req & ~ack_q;
    irq_en_d = wr_ctrl ? wdata_q[1] : irq_en_q;
    shadow_d = (wr && (addr_q == AddrPeriod)) ? wdata_q : shadow_q;
    period_d = (state_d == StArm) ? shadow_d : period_q;
    done_d   = done_evt | (done_q & ~rd_status);
    err_d    = (start_req & busy) | (err_q & ~rd_status);
    events_d = events_q;
    if (wr && (addr_q == AddrEvents)) begin
      events_d = '0;
    end else if (done_evt) begin
      events_d = events_q + EVT_W'(1);
    end
    irq_d = irq_en_d & done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 2'd0;
      wdata_q  <= 4'd0;
      irq_en_q <= 1'b0;
      shadow_q <= 4'd0;
      period_q <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      events_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      irq_en_q <= irq_en_d;
      shadow_q <= shadow_d;
      period_q <= period_d;
      done_q   <= done_d;
      err_q    <= err_d;
      events_q <= events_d;
      irq_q    <= irq_d;
      if (bus_req && !ack_q) begin
        we_q    <= bus_we;
        addr_q  <= bus_addr;
        wdata_q <= bus_wdata[3:0];
      end
    end
  end

`ifdef TIMER_HOST_AUTORELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_q <= 1'b0;
    end else if (wr_ctrl) begin
      auto_q <= wdata_q[2];
    end
  end
`else
  assign auto_q = 1'b0;
`endif

endmodule

// File: tb/tb_timer_host_if.sv
// Directed bench for timer_host_if: bus access timing, start/done handshake, status semantics,
// event counter wrap, coincidence priorities and asynchronous reset.
module tb_timer_host_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_req, bus_we;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic       bus_ack;
  logic       timer_done, timer_start, irq;
  logic [3:0] timer_period;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] rdv;

  timer_host_if #(.EVT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .timer_done   (timer_done),
    .timer_start  (timer_start),
    .timer_period (timer_period),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Request on one negedge; ack must be up by the next one.
  task automatic bus_access(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd);
    @(negedge clk);
    chk("ack_before_req", bus_ack, 1'b0);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    @(negedge clk);
    chk("ack_after_req", bus_ack, 1'b1);
    rd = bus_rdata;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = 8'h00;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    logic [7:0] dummy;
    bus_access(1'b1, addr, data, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    logic [7:0] r;
    bus_access(1'b0, addr, 8'h00, r);
    chk(tag, r, exp);
  endtask

  task automatic done_pulse();
    @(negedge clk);
    timer_done = 1'b1;
    @(negedge clk);
    timer_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = 8'h00;
    timer_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_irq", irq, 1'b0);
    chk("rst_start", timer_start, 1'b0);
    chk("rst_period", timer_period, 4'd0);
    chk("rst_ack", bus_ack, 1'b0);
    chk("rst_rdata", bus_rdata, 8'h00);
    rst = 1'b0;

    rd_chk("rst_ctrl", 2'd0, 8'h00);
    rd_chk("rst_period_reg", 2'd1, 8'h00);
    rd_chk("rst_status", 2'd2, 8'h00);
    rd_chk("rst_events", 2'd3, 8'h00);

    // Basic start/done with interrupt
    wr(2'd1, 8'hF5);
    rd_chk("period_upper_zero", 2'd1, 8'h05);
    wr(2'd0, 8'h03);
    @(negedge clk);
    chk("start_pulse", timer_start, 1'b1);
    chk("start_period", timer_period, 4'd5);
    @(negedge clk);
    chk("start_one_cycle", timer_start, 1'b0);
    repeat (5) @(negedge clk);
    done_pulse();
    chk("irq_set", irq, 1'b1);
    chk("no_restart", timer_start, 1'b0);
    rd_chk("status_done", 2'd2, 8'h01);
    chk("irq_in_read_ack", irq, 1'b1);
    @(negedge clk);
    chk("irq_cleared", irq, 1'b0);
    rd_chk("events_one", 2'd3, 8'h01);
    rd_chk("status_cleared", 2'd2, 8'h00);

    // Writes while busy
    wr(2'd0, 8'h01);
    @(negedge clk);
    chk("start2_pulse", timer_start, 1'b1);
    chk("start2_period", timer_period, 4'd5);
    @(negedge clk);
    wr(2'd0, 8'h01);
    @(negedge clk);
    chk("busy_start_ignored", timer_start, 1'b0);
    wr(2'd1, 8'h09);
    chk("busy_period_held", timer_period, 4'd5);
    rd_chk("status_busy_err", 2'd2, 8'h06);
    rd_chk("status_err_cleared", 2'd2, 8'h02);
    done_pulse();
    chk("irq_disabled", irq, 1'b0);
    rd_chk("status_done2", 2'd2, 8'h01);
    wr(2'd0, 8'h01);
    @(negedge clk);
    chk("start3_pulse", timer_start, 1'b1);
    chk("start3_new_period", timer_period, 4'd9);
    @(negedge clk);
    done_pulse();
    rd_chk("status_done3", 2'd2, 8'h01);

    // Auto-reload
    wr(2'd3, 8'h00);
    wr(2'd0, 8'h05);
    @(negedge clk);
    chk("auto_first_start", timer_start, 1'b1);
`ifdef TIMER_HOST_AUTORELOAD_EN
    rd_chk("ctrl_auto_rd", 2'd0, 8'h04);
    for (int i = 0; i < 3; i++) begin
      done_pulse();
      chk("auto_restart", timer_start, 1'b1);
    end
    rd_chk("auto_events", 2'd3, 8'h03);
    wr(2'd0, 8'h00);
    done_pulse();
    chk("auto_stopped", timer_start, 1'b0);
    rd_chk("auto_status_idle", 2'd2, 8'h01);
`else
    rd_chk("ctrl_no_auto_rd", 2'd0, 8'h00);
    done_pulse();
    chk("no_auto_restart", timer_start, 1'b0);
    rd_chk("no_auto_events", 2'd3, 8'h01);
    rd_chk("no_auto_status", 2'd2, 8'h01);
`endif

    // Event counter wrap
    wr(2'd3, 8'h00);
    for (int i = 0; i < 255; i++) begin
      wr(2'd0, 8'h01);
      @(negedge clk);
      done_pulse();
    end
    rd_chk("events_ff", 2'd3, 8'hFF);
    wr(2'd0, 8'h01);
    @(negedge clk);
    done_pulse();
    rd_chk("events_wrap", 2'd3, 8'h00);
    rd_chk("status_after_wrap", 2'd2, 8'h01);

    // Done coinciding with STATUS read: set wins, data shows pre-set value
    wr(2'd0, 8'h01);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("coinc_rd_ack_idle", bus_ack, 1'b0);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 2'd2;
    @(negedge clk);
    chk("coinc_rd_ack", bus_ack, 1'b1);
    rdv = bus_rdata;
    chk("coinc_rd_data", rdv, 8'h02);
    timer_done = 1'b1;
    bus_req = 1'b0; bus_addr = 2'd0;
    @(negedge clk);
    timer_done = 1'b0;
    rd_chk("coinc_done_kept", 2'd2, 8'h01);

    // Done coinciding with EVENTS write: clear wins
    wr(2'd0, 8'h01);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 2'd3; bus_wdata = 8'h00;
    @(negedge clk);
    chk("coinc_wr_ack", bus_ack, 1'b1);
    timer_done = 1'b1;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = 2'd0;
    @(negedge clk);
    timer_done = 1'b0;
    rd_chk("coinc_events_cleared", 2'd3, 8'h00);
    rd_chk("coinc_status", 2'd2, 8'h01);

    // Asynchronous reset mid-run
    wr(2'd0, 8'h03);
    @(negedge clk);
    @(negedge clk);
    done_pulse();
    chk("pre_rst_irq", irq, 1'b1);
    wr(2'd0, 8'h03);
    @(negedge clk);
    chk("pre_rst_start", timer_start, 1'b1);
    chk("pre_rst_period", timer_period, 4'd9);
    rst = 1'b1;
    #1;
    chk("async_rst_start", timer_start, 1'b0);
    chk("async_rst_irq", irq, 1'b0);
    chk("async_rst_period", timer_period, 4'd0);
    chk("async_rst_ack", bus_ack, 1'b0);
    chk("async_rst_rdata", bus_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    done_pulse();
    chk("post_rst_done_irq", irq, 1'b0);
    chk("post_rst_done_start", timer_start, 1'b0);
    rd_chk("post_rst_status", 2'd2, 8'h00);
    rd_chk("post_rst_events", 2'd3, 8'h00);
    rd_chk("post_rst_period", 2'd1, 8'h00);
    rd_chk("post_rst_ctrl", 2'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/timer_host_if.md
# timer_host_if

Processor-side host interface for the 4-bit period timer. It takes register writes from the microprocessor bus and turns them into the timer's start pulse and period value. It then catches the timer's one-cycle completion pulse in sticky status, counts completion events and raises an interrupt. The block sits between the CPU bus decoder and the timer FSM: `timer_start` drives the timer's start input and `timer_done` is taken from the timer's end-of-count output.

## Interface
Parameters:
- `EVT_W`, default 8: width of the completion event counter.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `bus_req`, in, 1: access request; held high until `bus_ack`.
- `bus_we`, in, 1: 1 = write, 0 = read; stable while `bus_req` is high.
- `bus_addr`, in, 2: register select.
- `bus_wdata`, in, 8: write data.
- `bus_rdata`, out, 8: read data, valid in the `bus_ack` cycle, 0 otherwise.
- `bus_ack`, out, 1: one-cycle access completion.
- `timer_done`, in, 1: one-cycle end-of-count pulse from the timer.
- `timer_start`, out, 1: one-cycle start pulse to the timer.
- `timer_period`, out, 4: period presented to the timer; stable while busy.
- `irq`, out, 1: level interrupt.

Reset values: all outputs 0; all registers 0; FSM in IDLE.

## Operation
Register map:
- 0 CTRL (R/W):
  - bit0 START: write-1 action, reads 0.
  - bit1 IRQ_EN.
  - bit2 AUTO: present only with the macro.
- 1 PERIOD (R/W): bits[3:0] shadow period; bits[7:4] read 0.
- 2 STATUS (R, read-to-clear):
  - bit0 DONE: sticky.
  - bit1 BUSY: live, not cleared by read.
  - bit2 ERR: sticky; set by START written while busy.
- 3 EVENTS (R): EVT_W-bit completion counter, wraps 2^EVT_W−1 → 0, zero-extended/truncated to 8 bits; write clears it.

FSM states:
- IDLE → ARM on an accepted write to CTRL with bit0 = 1.
- ARM → RUN unconditionally. In ARM, `timer_start` = 1 and `timer_period` is loaded from the PERIOD shadow.
- RUN → IDLE on `timer_done`. With AUTO set: RUN → ARM on `timer_done`.
- Undefined state encodings → IDLE.

BUSY = state ≠ IDLE.

Rules:
- START written while BUSY: ignored; set ERR; the timer sees no extra pulse.
- PERIOD written while BUSY: updates the shadow only; takes effect at the next ARM.
- `timer_done` outside RUN: ignored; DONE and EVENTS unchanged.
- `irq` = IRQ_EN & DONE, registered.
- Period 0 is legal and is passed through unchanged.

## Timing
- Bus access:
  - `bus_req` is sampled in cycle T; `bus_ack` and `bus_rdata` are driven in T+1.
  - No new access is accepted in the ack cycle, so an access takes at minimum 2 cycles.
  - The write takes effect at the end of T+1.
- Start: write ack in cycle T → `timer_start` high in T+1 only, BUSY = 1 from T+1.
- Completion: `timer_done` in cycle N → DONE = 1, EVENTS+1 and `irq` (if enabled) all at N+1; BUSY = 0 at N+1.
- AUTO: `timer_done` in N → `timer_start` again at N+1, BUSY stays 1. Clearing AUTO mid-run stops the block after the current period.
- STATUS read in the same cycle DONE/ERR would be set: the set wins and the bit stays 1. The returned data shows the pre-set value.
- EVENTS write coinciding with an increment: the clear wins.
- `rst` asserted mid-run: everything returns to reset values immediately; `timer_start` drops asynchronously.

## Configuration
- `TIMER_HOST_AUTORELOAD_EN` defined:
  - CTRL bit2 AUTO is implemented and readable.
  - RUN → ARM on `timer_done` when AUTO = 1.
- Undefined:
  - CTRL bit2 reads 0 and writes to it are ignored.
  - RUN always returns to IDLE.

## Test plan
- Reset then read all 4 addresses → all 0; `irq` = 0, `timer_start` = 0, `bus_ack` one cycle after each `bus_req`.
- Write PERIOD = 5, CTRL = 0x03 → one `timer_start` pulse with `timer_period` = 5. Drive `timer_done` 7 cycles later → next cycle STATUS = 0x01 on read, `irq` = 1, EVENTS = 1. Reading STATUS drops `irq` one cycle later.
- While BUSY: write CTRL = 0x01 and PERIOD = 9 → no second start, `timer_period` stays 5. STATUS reads 0x06. The next start presents 9.
- With the macro: CTRL = 0x05, pulse `timer_done` 3 times → 3 restarts each one cycle after done, EVENTS = 3. Clear AUTO → after the next done, BUSY = 0.
- EVTS wrap with EVT_W = 8: 256 completions → EVENTS = 0. Done coinciding with a STATUS read → DONE still 1 on the next read.
- Assert `rst` in RUN → outputs 0 within the same cycle; a later `timer_done` has no effect.
